// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline hazard/control unit (load-use, MUL/DIV hold, redirect squash, exit freeze); optional counters via PIPE_CTRL_PERF_EN
module pipe_ctrl #(
    parameter int MUL_LAT = 3,
    parameter int DIV_LAT = 34,
    parameter int CNT_W   = $clog2(DIV_LAT > MUL_LAT ? DIV_LAT : MUL_LAT) + 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [4:0] id_rs1_i,
    input  logic [4:0] id_rs2_i,
    input  logic       id_use_rs1_i,
    input  logic       id_use_rs2_i,
    input  logic       ex_load_i,
    input  logic [4:0] ex_rd_i,
    input  logic       ex_md_i,
    input  logic       ex_is_div_i,
    input  logic       ex_redirect_i,
    input  logic       wb_exit_i,
    output logic       pc_stall_o,
    output logic       if_id_stall_o,
    output logic       if_id_flush_o,
    output logic       id_ex_stall_o,
    output logic       id_ex_flush_o,
    output logic       ex_mem_flush_o,
    output logic       md_done_o,
    output logic       halted_o
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [63:0] perf_stall_cycles_o,
    output logic [63:0] perf_flush_cnt_o
`endif
);
    typedef enum logic [1:0] {IDLE, BUSY, HALT} state_t;
    state_t state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx, lat_m1;
    logic lu, md_stall, hold, act;
    always_comb begin
        lat_m1 = ex_is_div_i ? CNT_W'(DIV_LAT - 1) : CNT_W'(MUL_LAT - 1);
        hold = state == HALT || wb_exit_i;
        md_stall = !hold && ex_md_i && cnt != lat_m1;
        lu = ex_load_i && ex_rd_i != 5'd0 &&
             ((id_use_rs1_i && id_rs1_i == ex_rd_i) || (id_use_rs2_i && id_rs2_i == ex_rd_i));
        act = !reset;
        pc_stall_o = act && (hold || md_stall || (!ex_redirect_i && lu));
        if_id_stall_o = pc_stall_o;
        id_ex_stall_o = act && (hold || md_stall);
        ex_mem_flush_o = id_ex_stall_o;
        if_id_flush_o = act && !hold && !md_stall && ex_redirect_i;
        id_ex_flush_o = act && !hold && !md_stall && (ex_redirect_i || lu);
        md_done_o = act && ex_md_i && cnt == lat_m1 && state != HALT;
        halted_o = act && state == HALT;
        state_nx = hold ? HALT : md_stall ? BUSY : IDLE;
        cnt_nx = md_stall ? cnt + 1'b1 : '0;
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            cnt <= '0;
        end else begin
            state <= state_nx;
            cnt <= cnt_nx;
        end
    end
`ifdef PIPE_CTRL_PERF_EN
    // counts freeze once halted; the exit cycle itself still counts as a stall
    always_ff @(posedge clock) begin
        if (reset) begin
            perf_stall_cycles_o <= '0;
            perf_flush_cnt_o <= '0;
        end else if (state != HALT) begin
            perf_stall_cycles_o <= perf_stall_cycles_o + (pc_stall_o ? 64'd1 : 64'd0);
            perf_flush_cnt_o <= perf_flush_cnt_o + (if_id_flush_o ? 64'd1 : 64'd0);
        end
    end
`endif
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed self-checking bench for pipe_ctrl
module tb_pipe_ctrl;
    logic clock = 0, reset = 1;
    logic [4:0] id_rs1_i = 0, id_rs2_i = 0, ex_rd_i = 0;
    logic id_use_rs1_i = 0, id_use_rs2_i = 0, ex_load_i = 0, ex_md_i = 0;
    logic ex_is_div_i = 0, ex_redirect_i = 0, wb_exit_i = 0;
    logic pc_stall_o, if_id_stall_o, if_id_flush_o, id_ex_stall_o;
    logic id_ex_flush_o, ex_mem_flush_o, md_done_o, halted_o;
`ifdef PIPE_CTRL_PERF_EN
    logic [63:0] perf_stall_cycles_o, perf_flush_cnt_o;
`endif
    int n_chk = 0, n_fail = 0;

    // {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_flush, md_done, halted}
    localparam logic [7:0] O_NONE = 8'b0000_0000;
    localparam logic [7:0] O_LU   = 8'b1100_1000;
    localparam logic [7:0] O_MD   = 8'b1101_0100;
    localparam logic [7:0] O_DONE = 8'b0000_0010;
    localparam logic [7:0] O_RED  = 8'b0010_1000;
    localparam logic [7:0] O_RDN  = 8'b0010_1010;
    localparam logic [7:0] O_HALT = 8'b1101_0101;

    pipe_ctrl dut (
        .clock(clock), .reset(reset),
        .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i),
        .id_use_rs1_i(id_use_rs1_i), .id_use_rs2_i(id_use_rs2_i),
        .ex_load_i(ex_load_i), .ex_rd_i(ex_rd_i),
        .ex_md_i(ex_md_i), .ex_is_div_i(ex_is_div_i),
        .ex_redirect_i(ex_redirect_i), .wb_exit_i(wb_exit_i),
        .pc_stall_o(pc_stall_o), .if_id_stall_o(if_id_stall_o),
        .if_id_flush_o(if_id_flush_o), .id_ex_stall_o(id_ex_stall_o),
        .id_ex_flush_o(id_ex_flush_o), .ex_mem_flush_o(ex_mem_flush_o),
        .md_done_o(md_done_o), .halted_o(halted_o)
`ifdef PIPE_CTRL_PERF_EN
        , .perf_stall_cycles_o(perf_stall_cycles_o), .perf_flush_cnt_o(perf_flush_cnt_o)
`endif
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    // inputs are driven 1 time unit after the edge; outputs are checked 1 unit later
    task automatic cyc(input string tag, input logic [7:0] exp);
        #1;
        check(tag, {24'd0, pc_stall_o, if_id_stall_o, if_id_flush_o, id_ex_stall_o,
                    id_ex_flush_o, ex_mem_flush_o, md_done_o, halted_o}, {24'd0, exp});
        @(posedge clock);
        #1;
    endtask

    task automatic clr;
        {id_rs1_i, id_rs2_i, ex_rd_i} = '0;
        {id_use_rs1_i, id_use_rs2_i, ex_load_i, ex_md_i, ex_is_div_i, ex_redirect_i, wb_exit_i} = '0;
    endtask

    initial begin
        @(posedge clock);
        #1;
        ex_md_i = 1; wb_exit_i = 1; ex_load_i = 1; ex_rd_i = 5; id_use_rs2_i = 1; id_rs2_i = 5;
        cyc("reset_outputs", O_NONE);
        clr(); reset = 0;
        cyc("idle", O_NONE);
        ex_load_i = 1; ex_rd_i = 5; id_use_rs2_i = 1; id_rs2_i = 5;
        cyc("lu_rs2", O_LU);
        ex_load_i = 0;
        cyc("lu_clear", O_NONE);
        ex_load_i = 1; ex_rd_i = 0; id_rs2_i = 0;
        cyc("lu_rd0", O_NONE);
        ex_rd_i = 7; id_use_rs2_i = 0; id_use_rs1_i = 1; id_rs1_i = 7;
        cyc("lu_rs1", O_LU);
        id_use_rs1_i = 0;
        cyc("lu_nouse", O_NONE);
        clr();
        ex_md_i = 1; ex_is_div_i = 1;
        for (int i = 1; i <= 33; i++) cyc($sformatf("div_stall_%0d", i), O_MD);
        cyc("div_done", O_DONE);
        clr();
        cyc("div_after", O_NONE);
        ex_md_i = 1;
        for (int k = 0; k < 2; k++) begin
            cyc($sformatf("mul%0d_s1", k), O_MD);
            cyc($sformatf("mul%0d_s2", k), O_MD);
            cyc($sformatf("mul%0d_done", k), O_DONE);
        end
        clr();
        ex_redirect_i = 1; ex_load_i = 1; ex_rd_i = 9; id_use_rs1_i = 1; id_rs1_i = 9;
        cyc("redirect_lu", O_RED);
        ex_md_i = 1;
        cyc("md_over_redirect_1", O_MD);
        cyc("md_over_redirect_2", O_MD);
        cyc("redirect_on_done", O_RDN);
        clr();
        ex_md_i = 1; ex_is_div_i = 1;
        for (int i = 1; i <= 9; i++) cyc($sformatf("divr_stall_%0d", i), O_MD);
        reset = 1;
        cyc("reset_mid_div", O_NONE);
        reset = 0;
        for (int i = 1; i <= 33; i++) cyc($sformatf("div2_stall_%0d", i), O_MD);
        cyc("div2_done", O_DONE);
        clr();
        wb_exit_i = 1;
        cyc("exit_cycle", O_MD);
        wb_exit_i = 0;
        cyc("halted", O_HALT);
        ex_md_i = 1; ex_redirect_i = 1;
        cyc("halt_md_redirect_1", O_HALT);
        cyc("halt_md_redirect_2", O_HALT);
        clr();
        for (int i = 0; i < 4; i++) cyc($sformatf("halt_hold_%0d", i), O_HALT);
        reset = 1;
        cyc("halt_reset", O_NONE);
        reset = 0;
        cyc("after_halt_reset", O_NONE);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Central hazard/control unit for the 5-stage RV64IM pipeline; the driver of the stall/flush inputs consumed by the IF/ID, ID/EX and EX/MEM pipeline registers and of the PC-hold enable.
- Detects load-use hazards, holds EX for multi-cycle MUL/DIV, squashes younger stages on EX redirect, freezes the core once the exit instruction reaches WB.

Parameters:
- MUL_LAT, 3, total EX cycles for a MUL* op (>=1)
- DIV_LAT, 34, total EX cycles for a DIV*/REM* op (>=1)
- CNT_W, $clog2(DIV_LAT>MUL_LAT?DIV_LAT:MUL_LAT)+1, latency counter width

Ports:
- clock  in  1  core clock
- reset  in  1  synchronous, active-high reset
- id_rs1_i  in  5  rs1 of instruction in ID
- id_rs2_i  in  5  rs2 of instruction in ID
- id_use_rs1_i  in  1  ID instruction reads rs1
- id_use_rs2_i  in  1  ID instruction reads rs2
- ex_load_i  in  1  ID/EX load_o
- ex_rd_i  in  5  ID/EX rd_o
- ex_md_i  in  1  op in EX is MUL/DIV
- ex_is_div_i  in  1  with ex_md_i: 1=DIV/REM, 0=MUL
- ex_redirect_i  in  1  EX branch taken / jump, PC must load target
- wb_exit_i  in  1  MEM/WB exit_o
- pc_stall_o  out  1  hold PC
- if_id_stall_o  out  1  to IF/ID stall_i
- if_id_flush_o  out  1  to IF/ID flush_i
- id_ex_stall_o  out  1  to ID/EX stall_i
- id_ex_flush_o  out  1  to ID/EX flush_i
- ex_mem_flush_o  out  1  to EX/MEM flush_i
- md_done_o  out  1  final EX cycle of MUL/DIV; EX unit selects result
- halted_o  out  1  core frozen

Behaviour:
- Clock/reset: one clock `clock`; reset is synchronous, active-high on `reset`. Reset: state=IDLE, cnt=0; all outputs 0 while reset high. Reset mid-BUSY aborts the op, no md_done_o.
- States: IDLE, BUSY, HALT (registered); cnt registered; all outputs combinational from state, cnt, inputs.
- lat = ex_is_div_i ? DIV_LAT : MUL_LAT.
- md_stall = ex_md_i && (cnt != lat-1); md_done_o = ex_md_i && (cnt == lat-1) && state!=HALT.
- IDLE: ex_md_i && lat>1 -> BUSY, cnt<=1. ex_md_i && lat==1 -> md_done_o same cycle, no stall, stay IDLE.
- BUSY: cnt<=cnt+1 while md_stall; on md_done_o cycle cnt<=0 -> IDLE. Back-to-back MUL/DIV restarts from IDLE the next cycle (cnt=0).
- Load-use: lu = ex_load_i && ex_rd_i!=0 && ((id_use_rs1_i && id_rs1_i==ex_rd_i) || (id_use_rs2_i && id_rs2_i==ex_rd_i)).
- Priority, highest first, one action per cycle:
  1. HALT or wb_exit_i: pc_stall, if_id_stall, id_ex_stall, ex_mem_flush =1; next state HALT; halted_o=1 from the cycle after wb_exit_i until reset.
  2. md_stall: pc_stall, if_id_stall, id_ex_stall =1; ex_mem_flush=1 (bubble into MEM); redirect and lu ignored.
  3. ex_redirect_i: if_id_flush=1, id_ex_flush=1, pc_stall=0; lu ignored (younger instr squashed).
  4. lu: pc_stall=1, if_id_stall=1, id_ex_flush=1 (one bubble); clears next cycle as the load leaves EX.
  5. else: all 0.
- A redirecting instr never has ex_md_i; both high together is treated per priority (MD wins, redirect sampled on md_done_o cycle).
- Stall and flush of the same register never both asserted.

Optional Feature:
- Macro PIPE_CTRL_PERF_EN. Defined: adds outputs perf_stall_cycles_o[63:0] (cycles with pc_stall_o=1, excluding HALT) and perf_flush_cnt_o[63:0] (cycles with if_id_flush_o=1); both reset to 0, wrap at 2^64, frozen in HALT. Undefined: ports and counters absent, all other behaviour identical.

Test Plan:
- Load x5 in EX (ex_load_i=1, ex_rd_i=5), ID reads rs2=5 -> exactly 1 cycle pc_stall=if_id_stall=id_ex_flush=1; rd=0 same stimulus -> no stall.
- DIV in EX, DIV_LAT=34 -> 33 cycles pc/if_id/id_ex stall + ex_mem_flush, md_done_o=1 on cycle 34, then all 0.
- MUL then MUL back-to-back (MUL_LAT=3) -> stall 2, done, stall 2, done; cnt returns to 0 between.
- ex_redirect_i with simultaneous lu -> if_id_flush=id_ex_flush=1, pc_stall=0, no load-use stall.
- reset asserted at DIV cycle 10 -> outputs 0, next DIV takes full 34 cycles.
- wb_exit_i pulse -> halted_o=1 next cycle, all stalls + ex_mem_flush held indefinitely; ex_md_i/redirect ignored; cleared only by reset.
